// File: rtl/encrypter_core_pkg.sv
// Shared constants and types for the encrypter lane.
package encrypter_core_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int KEY_WIDTH       = 32;
    localparam int KEY_CHUNKS      = KEY_WIDTH / DATA_WIDTH;
    localparam int ROT_WIDTH       = $clog2(KEY_WIDTH);
    localparam int CHUNK_CNT_WIDTH = (KEY_CHUNKS > 1) ? $clog2(KEY_CHUNKS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_XOR    = 2'd2,
        ST_OUT    = 2'd3
    } enc_state_e;

    // One-bit rotate right of a key word.
    function automatic logic [KEY_WIDTH-1:0] ror1(input logic [KEY_WIDTH-1:0] k);
        return {k[0], k[KEY_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/encrypter_core_key_chunk_loader.sv
// Assembles the shared key from DATA_WIDTH chunks, chunk 0 in the LSBs.
module key_chunk_loader
    import encrypter_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] chunk_i,
    output logic [KEY_WIDTH-1:0]  key_o,
    output logic                  key_loaded_o,
    output logic                  load_busy_o
);

    logic [KEY_WIDTH-1:0]       key_q, key_d;
    logic [CHUNK_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                       loaded_q, loaded_d;

    // Write the addressed chunk; first chunk invalidates the key, last one validates it.
    always_comb begin
        key_d    = key_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        if (wr_en_i) begin
            key_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = chunk_i;
            if (cnt_q == '0) begin
                loaded_d = 1'b0;
            end
            if (cnt_q == CHUNK_CNT_WIDTH'(KEY_CHUNKS - 1)) begin
                cnt_d    = '0;
                loaded_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CHUNK_CNT_WIDTH'(1);
            end
        end
    end

    // Key, chunk counter and loaded flag; reset discards any partial load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_q    <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            key_q    <= key_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    assign key_o        = key_q;
    assign key_loaded_o = loaded_q;
    assign load_busy_o  = (cnt_q != '0);

endmodule

// File: rtl/encrypter_core.sv
// One encryption lane: rotate key copy by r, XOR packet with low key bits, hand off.
module encrypter_core
    import encrypter_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enc_program,
    input  logic [DATA_WIDTH-1:0] enc_data_in,
    input  logic                  enc_data_ready,
    input  logic [ROT_WIDTH-1:0]  enc_key_rotation,
    output logic                  enc_ready,
    output logic                  key_loaded,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_accept,
    output logic                  drop_err
);

    enc_state_e            state_q, state_d;
    logic [KEY_WIDTH-1:0]  key;
    logic                  key_loaded_w;
    logic                  load_busy;

    logic [DATA_WIDTH-1:0] pkt_q;
    logic [ROT_WIDTH-1:0]  rot_cnt_q;
    logic [KEY_WIDTH-1:0]  work_key_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  drop_err_q;

    logic                  prog_we;
    logic                  pkt_take;
    logic                  drop_set;
    logic                  enc_ready_c;

    key_chunk_loader u_loader (
        .clk          (clk),
        .reset        (reset),
        .wr_en_i      (prog_we),
        .chunk_i      (enc_data_in),
        .key_o        (key),
        .key_loaded_o (key_loaded_w),
        .load_busy_o  (load_busy)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: a program chunk in IDLE always pre-empts a packet.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!enc_program && enc_data_ready && key_loaded_w) state_d = ST_ROTATE;
            ST_ROTATE: if (rot_cnt_q == '0) state_d = ST_XOR;
            ST_XOR:    state_d = ST_OUT;
            ST_OUT:    if (out_accept) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control outputs: strobe qualification and the drop detector.
    always_comb begin
        prog_we     = (state_q == ST_IDLE) && enc_program;
        pkt_take    = (state_q == ST_IDLE) && enc_data_ready && key_loaded_w && !enc_program;
        drop_set    = (enc_data_ready && !pkt_take) ||
                      (enc_program && (state_q != ST_IDLE));
        enc_ready_c = (state_q == ST_IDLE) && key_loaded_w && !load_busy;
    end

    // Datapath: latch packet, rotate working key, form and hold ciphertext.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_q       <= '0;
            rot_cnt_q   <= '0;
            work_key_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            drop_err_q  <= 1'b0;
        end else begin
            if (drop_set) drop_err_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (pkt_take) begin
                        pkt_q      <= enc_data_in;
                        rot_cnt_q  <= enc_key_rotation;
                        work_key_q <= key;
                    end
                end
                ST_ROTATE: begin
                    if (rot_cnt_q != '0) begin
                        work_key_q <= ror1(work_key_q);
                        rot_cnt_q  <= rot_cnt_q - ROT_WIDTH'(1);
                    end
                end
                ST_XOR: begin
                    out_data_q  <= pkt_q ^ work_key_q[DATA_WIDTH-1:0];
                    out_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (out_accept) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign enc_ready  = enc_ready_c;
    assign key_loaded = key_loaded_w;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_encrypter_core.sv
// Directed bench for encrypter_core: vector table plus multi-cycle corner cases.
module tb_encrypter_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enc_program = 1'b0;
    logic [7:0] enc_data_in = 8'h00;
    logic       enc_data_ready = 1'b0;
    logic [4:0] enc_key_rotation = 5'd0;
    logic       enc_ready;
    logic       key_loaded;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_accept = 1'b0;
    logic       drop_err;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    encrypter_core dut (
        .clk              (clk),
        .reset            (reset),
        .enc_program      (enc_program),
        .enc_data_in      (enc_data_in),
        .enc_data_ready   (enc_data_ready),
        .enc_key_rotation (enc_key_rotation),
        .enc_ready        (enc_ready),
        .key_loaded       (key_loaded),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_accept       (out_accept),
        .drop_err         (drop_err)
    );

    typedef struct {
        logic [7:0] pkt;
        logic [4:0] rot;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_key(input logic [31:0] k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            enc_program = 1'b1;
            enc_data_in = k[i*8 +: 8];
        end
        @(negedge clk);
        enc_program = 1'b0;
    endtask

    task automatic start_pkt(input logic [7:0] pkt, input logic [4:0] rot);
        @(negedge clk);
        enc_data_ready   = 1'b1;
        enc_data_in      = pkt;
        enc_key_rotation = rot;
        @(negedge clk);
        enc_data_ready   = 1'b0;
    endtask

    // Counts edges after the acceptance edge until out_valid rises (bounded).
    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_accept(input string tag);
        @(negedge clk);
        out_accept = 1'b1;
        @(negedge clk);
        out_accept = 1'b0;
        check({tag, "_valid_after_accept"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_after_accept"}, 32'(enc_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;

        vecs[0] = '{pkt: 8'hAA, rot: 5'd0,  exp_data: 8'hD2};
        vecs[1] = '{pkt: 8'hAA, rot: 5'd8,  exp_data: 8'hFC};
        vecs[2] = '{pkt: 8'hAA, rot: 5'd4,  exp_data: 8'hCD};
        vecs[3] = '{pkt: 8'h55, rot: 5'd16, exp_data: 8'h61};
        vecs[4] = '{pkt: 8'h00, rot: 5'd31, exp_data: 8'hF0};
        vecs[5] = '{pkt: 8'hFF, rot: 5'd1,  exp_data: 8'hC3};

        // Reset state
        do_reset();
        check("rst_key_loaded", 32'(key_loaded), 32'd0);
        check("rst_enc_ready",  32'(enc_ready),  32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_data",   32'(out_data),   32'd0);
        check("rst_drop_err",   32'(drop_err),   32'd0);

        // Packet before any key is dropped
        start_pkt(8'hAA, 5'd0);
        repeat (6) @(negedge clk);
        check("nokey_out_valid", 32'(out_valid), 32'd0);
        check("nokey_drop_err",  32'(drop_err),  32'd1);

        // Key load 0x12345678
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("load_kl_before_last", 32'(key_loaded), 32'd0);
            enc_program = 1'b1;
            enc_data_in = 8'h78 >> 0;
            case (i)
                0: enc_data_in = 8'h78;
                1: enc_data_in = 8'h56;
                2: enc_data_in = 8'h34;
                default: enc_data_in = 8'h12;
            endcase
        end
        @(negedge clk);
        enc_program = 1'b0;
        check("load_key_loaded", 32'(key_loaded), 32'd1);
        check("load_enc_ready",  32'(enc_ready),  32'd1);

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            start_pkt(vecs[v].pkt, vecs[v].rot);
            check($sformatf("v%0d_ready_busy", v), 32'(enc_ready), 32'd0);
            wait_valid(k);
            check($sformatf("v%0d_latency", v), 32'(k), 32'(vecs[v].rot) + 32'd2);
            check($sformatf("v%0d_data", v), 32'(out_data), 32'(vecs[v].exp_data));
            do_accept($sformatf("v%0d", v));
        end
        check("table_no_drop", 32'(drop_err), 32'd0);

        // Output held under backpressure
        start_pkt(8'hAA, 5'd8);
        wait_valid(k);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_data", c),  32'(out_data),  32'hFC);
            check($sformatf("hold%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d_ready", c), 32'(enc_ready), 32'd0);
        end
        do_accept("hold");

        // Packet strobe during ROTATE is dropped, result unaffected
        start_pkt(8'hAA, 5'd8);
        enc_data_ready = 1'b1;
        enc_data_in    = 8'h00;
        enc_key_rotation = 5'd0;
        @(negedge clk);
        enc_data_ready = 1'b0;
        wait_valid(k);
        check("busy_drop_data",  32'(out_data), 32'hFC);
        check("busy_drop_err",   32'(drop_err), 32'd1);
        do_accept("busy_drop");

        // Simultaneous program and packet: chunk wins
        do_reset();
        load_key(32'h12345678);
        check("simul_pre_drop", 32'(drop_err), 32'd0);
        @(negedge clk);
        enc_program    = 1'b1;
        enc_data_ready = 1'b1;
        enc_data_in    = 8'h11;
        enc_key_rotation = 5'd0;
        @(negedge clk);
        enc_program    = 1'b0;
        enc_data_ready = 1'b0;
        check("simul_key_loaded", 32'(key_loaded), 32'd0);
        check("simul_drop_err",   32'(drop_err),   32'd1);
        repeat (4) @(negedge clk);
        check("simul_no_output",  32'(out_valid),  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enc_program = 1'b1;
            case (i)
                0: enc_data_in = 8'h56;
                1: enc_data_in = 8'h34;
                default: enc_data_in = 8'h12;
            endcase
        end
        @(negedge clk);
        enc_program = 1'b0;
        check("simul_reload_done", 32'(key_loaded), 32'd1);
        start_pkt(8'hAA, 5'd0);
        wait_valid(k);
        check("simul_chunk1_data", 32'(out_data), 32'hBB);
        do_accept("simul");

        // Async reset during ROTATE
        do_reset();
        load_key(32'h12345678);
        start_pkt(8'hAA, 5'd20);
        repeat (3) @(negedge clk);
        check("rrot_pre_kl", 32'(key_loaded), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rrot_out_valid",  32'(out_valid),  32'd0);
        check("rrot_key_loaded", 32'(key_loaded), 32'd0);
        check("rrot_enc_ready",  32'(enc_ready),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Async reset while holding output
        load_key(32'h12345678);
        start_pkt(8'hAA, 5'd0);
        wait_valid(k);
        check("rout_pre_valid", 32'(out_valid), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rout_out_valid", 32'(out_valid), 32'd0);
        check("rout_out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Packet after reset without reload is dropped
        start_pkt(8'hAA, 5'd0);
        repeat (8) @(negedge clk);
        check("postrst_no_output", 32'(out_valid), 32'd0);
        check("postrst_drop_err",  32'(drop_err),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/encrypter_core.md
Name: encrypter_core

Overview:
- One encryption lane, instantiated NUM_ENCRYPTERS times directly downstream of the QSPI paralleliser.
- Loads the shared key in ENCRYPTER_WIDTH-sized chunks during programming.
- Per data packet: rotates its key copy by the packet's key-rotation value, XORs the packet with the low bits of the rotated key, and presents the result on a valid/accept handshake to the output collector.
- Its enc_ready output feeds the paralleliser's encrypters_ready vector.

Parameters:
- DATA_WIDTH, 8, packet width (equals ENCRYPTER_WIDTH).
- KEY_WIDTH, 32, key width; must be a multiple of DATA_WIDTH.
- KEY_CHUNKS, KEY_WIDTH/DATA_WIDTH, program pulses per key (derived).
- ROT_WIDTH, $clog2(KEY_WIDTH), width of rotation input (derived).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high.
- enc_program  input  1  chunk strobe; enc_data_in carries a key chunk.
- enc_data_in  input  DATA_WIDTH  key chunk or plaintext packet.
- enc_data_ready  input  1  plaintext strobe; enc_data_in carries a packet.
- enc_key_rotation  input  ROT_WIDTH  rotation amount for this packet.
- enc_ready  output  1  key loaded and lane idle.
- key_loaded  output  1  a full key is held.
- out_valid  output  1  ciphertext valid.
- out_data  output  DATA_WIDTH  ciphertext.
- out_accept  input  1  downstream takes out_data.
- drop_err  output  1  sticky; a strobe was ignored.

Behaviour:
- Reset (async): state IDLE, key=0, chunk_cnt=0, key_loaded=0, enc_ready=0, out_valid=0, out_data=0, drop_err=0. Reset mid-operation aborts everything, including a partial key and pending output.
- States:
  - IDLE: waiting for a chunk or packet.
  - ROTATE: iterative key rotation.
  - XOR: combine packet with rotated key.
  - OUT: hold result until accepted.
- Key load (IDLE only):
  - Each sampled enc_program writes enc_data_in to key[chunk_cnt*DATA_WIDTH +: DATA_WIDTH]; chunk 0 is the LSBs.
  - chunk_cnt increments and wraps to 0 after KEY_CHUNKS.
  - The first chunk of a load (chunk_cnt==0) clears key_loaded and enc_ready.
  - When the last chunk is written, key_loaded=1 and enc_ready=1 from the next cycle.
- Packet accept (IDLE, key_loaded=1, enc_data_ready=1, call this edge 0):
  - Latch the packet, latch the rotation, and copy the key to a working register.
  - enc_ready goes to 0; state goes to ROTATE.
- ROTATE:
  - Each cycle with rot_cnt!=0: working key rotates right by 1 bit, rot_cnt decrements. This covers edges 1..r.
  - At edge r+1 (rot_cnt==0): go to XOR.
  - r=0 therefore spends exactly one cycle in ROTATE.
- XOR: at edge r+2, out_data <= packet ^ work_key[DATA_WIDTH-1:0], out_valid <= 1, state goes to OUT.
- OUT:
  - out_data and out_valid are held stable until out_accept is sampled high.
  - At that edge: out_valid=0, enc_ready=1, state goes to IDLE.
  - out_accept while out_valid=0 is ignored.
- Latency: ciphertext is visible r+2 cycles after acceptance. The lane is back in IDLE on the edge out_accept is sampled.
- Rotation is modulo KEY_WIDTH by construction of ROT_WIDTH; the stored key is never modified by encryption.
- Ignored strobes (each sets drop_err, cleared only by reset):
  - enc_data_ready while not IDLE, or while key_loaded=0.
  - enc_program while not IDLE.
- enc_program and enc_data_ready in the same IDLE cycle: the program chunk wins, the packet is dropped, drop_err is set.

Decomposition:
- Shared package/constants header holds:
  - DATA_WIDTH, KEY_WIDTH, KEY_CHUNKS and ROT_WIDTH, shared with the paralleliser constants.
  - A state enum (IDLE, ROTATE, XOR, OUT).
- One natural sub-module: key_chunk_loader, containing the chunk counter, key register and key_loaded. It exposes the key and a load-in-progress flag.
- FSM, rotator and output register stay in encrypter_core.

Test Plan:
- Program chunks 0x78,0x56,0x34,0x12 → key_loaded=1 and enc_ready=1 one cycle after the 4th chunk. Then packet 0xAA with r=0 → out_valid at edge 2, out_data=0xD2.
- Same key, packet 0xAA with r=8 → out_valid exactly 10 cycles after acceptance, out_data=0xFC (rotated key 0x78123456). Same for r=4 → 0xCD.
- Hold out_accept low for 5 cycles → out_data stable 0xFC and enc_ready=0 throughout. Assert out_accept → next edge out_valid=0, enc_ready=1.
- enc_data_ready before any key load → no out_valid, drop_err=1. enc_data_ready during ROTATE → original result unaffected, drop_err=1.
- Simultaneous enc_program=1 (0x11) and enc_data_ready=1 in IDLE with key loaded → key_loaded=0 and chunk_cnt=1, no encryption, drop_err=1.
- Assert reset during ROTATE with r=20 → out_valid, key_loaded and enc_ready all 0 immediately (asynchronously). A subsequent packet without reload is dropped.
